vp_arbiter: RTL and testbench
=============================

VP_ARBITER -- requirements
Module: vp_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one vector component and of the scalar.
REQ-002 SHALL have parameter VECTOR_WIDTH, default 4: components per vector; vector ports are VECTOR_WIDTH*DATA_WIDTH (64) bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, used only under REQ-026.
REQ-004 SHALL have port clk, input, 1: clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports r0_start / r1_start, input, 1: one-cycle request pulse from shader pipeline 0/1.
REQ-007 SHALL have ports r0_operation / r1_operation, input, 4: vector operation code, passed through unmodified.
REQ-008 SHALL have ports r0_vec_a, r0_vec_b / r1_vec_a, r1_vec_b, input, 64: operand vectors.
REQ-009 SHALL have ports r0_scalar / r1_scalar, input, 16: scalar operand.
REQ-010 SHALL have ports r0_busy / r1_busy, output, 1: the port holds an unfinished request.
REQ-011 SHALL have ports r0_result / r1_result, output, 64: returned vector result.
REQ-012 SHALL have ports r0_result_valid / r1_result_valid, output, 1: one-cycle result strobe.
REQ-013 SHALL have ports vp_start (1), vp_operation (4), vp_vec_a (64), vp_vec_b (64), vp_scalar (16), all outputs: shared vector processor command.
REQ-014 SHALL have ports vp_busy (1), vp_result_valid (1), vp_result (64), all inputs: shared vector processor status and result.
REQ-015 SHALL have ports grant_id, output, 1 (port currently owning the VP), and timeout_err, output, 1 (sticky watchdog flag).

Function
REQ-016 SHALL capture each port's start as follows:
- rN_start high while rN_busy is low: payload latched into that port's holding register; rN_busy high from the next cycle.
- rN_start high while rN_busy is high: ignored, payload dropped.
REQ-017 SHALL run the FSM IDLE -> ISSUE -> WAIT -> RETURN -> IDLE:
- IDLE -> ISSUE when at least one port is pending and vp_busy is low.
- ISSUE -> WAIT after exactly one cycle.
- WAIT -> RETURN on vp_result_valid.
- RETURN -> IDLE after one cycle.
REQ-018 SHALL arbitrate round-robin: if both ports are pending in IDLE, grant the port not granted last; otherwise grant the only pending port; grant_id is updated on the IDLE->ISSUE transition.
REQ-019 SHALL drive vp_start high for exactly one cycle in ISSUE, with vp_operation/vec_a/vec_b/scalar taken from the granted holding register and held stable until the next ISSUE.
REQ-020 SHALL, at the edge sampling vp_result_valid in WAIT, load vp_result into the granted rN_result and assert rN_result_valid for exactly the RETURN cycle; the other port's outputs are unchanged.
REQ-021 SHALL clear the granted port's rN_busy on the RETURN->IDLE edge; rN_result holds its value until overwritten.
REQ-022 SHALL have latency as follows: idle arbiter, rN_start sampled at edge E -> vp_start high in the cycle after edge E+2; vp_result_valid sampled at edge F -> rN_result_valid high in the cycle after F.
REQ-023 SHALL ignore vp_result_valid outside WAIT; vp_busy high in IDLE SHALL hold off the grant indefinitely with no request loss.
REQ-024 SHALL accept a start from the non-owning port during any state.

Reset
REQ-025 SHALL, on rst_n low, immediately and asynchronously:
- force state to IDLE.
- clear both pending flags and all outputs to 0 (including grant_id and timeout_err).
- set the last-grant pointer to 1 so port 0 wins the first tie.
- discard any in-flight VP transaction; a vp_result_valid arriving after reset release is ignored per REQ-023.

Configuration
REQ-026 SHALL use macro VP_ARB_TIMEOUT_EN, behaving as follows:
- Defined: a counter counts WAIT cycles. On reaching TIMEOUT_CYCLES without vp_result_valid, the FSM enters RETURN with rN_result = 0, pulses rN_result_valid and sets timeout_err, which stays high until reset.
- Undefined: no counter; WAIT persists until vp_result_valid; timeout_err is tied to 0.

Verification
REQ-027 SHALL cover: r0_start with op=4, vec_a=FF00_0000_0000_FF00, scalar=0080 on an idle arbiter -> one vp_start with that payload two cycles later; vp_result=7F80_0000_0000_7F80 -> r0_result equals it, r0_result_valid high 1 cycle, r0_busy drops.
REQ-028 SHALL cover: r0_start and r1_start in the same cycle after reset -> port 0 served first, then port 1, with grant_id 0 then 1; four back-to-back paired requests alternate 0,1,0,1.
REQ-029 SHALL cover: second r0_start while r0_busy is high -> exactly one vp_start issued for port 0; r1_start in WAIT -> port 1 issued immediately after RETURN.
REQ-030 SHALL cover: vp_busy held high for 10 cycles with port 1 pending -> no vp_start until vp_busy falls; a stray vp_result_valid in IDLE -> no result strobe.
REQ-031 SHALL cover: rst_n pulsed low in WAIT -> all outputs 0 immediately; a later vp_result_valid -> no result strobe.
REQ-032 SHALL cover, with VP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no vp_result_valid -> result 0 strobed 8 cycles into WAIT and timeout_err=1; without the macro -> WAIT persists beyond 100 cycles.

Source files
------------

// File: rtl/vp_arbiter.sv
// -----------------------------------------------------------------------------
// vp_arbiter
// Round-robin arbiter sharing one vector processor (VP) between two shader
// pipeline request ports. Each port has a one-deep holding register. A single
// FSM (IDLE -> ISSUE -> WAIT -> RETURN) issues the granted payload to the VP,
// waits for its result and returns it to the owning port.
//
// Optional feature: define VP_ARB_TIMEOUT_EN to enable a WAIT watchdog of
// TIMEOUT_CYCLES cycles. On expiry a zero result is returned and the sticky
// timeout_err flag is set. Without the macro timeout_err is tied low.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rN_start                    one-cycle request pulse from pipeline N
//   rN_operation/vec_a/vec_b/scalar  request payload
//   rN_busy                     port N holds an unfinished request
//   rN_result, rN_result_valid  returned vector and one-cycle strobe
//   vp_start, vp_operation, vp_vec_a, vp_vec_b, vp_scalar  VP command
//   vp_busy, vp_result_valid, vp_result                    VP status/result
//   grant_id                    port currently owning the VP
//   timeout_err                 sticky watchdog flag
// -----------------------------------------------------------------------------
module vp_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned VECTOR_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic                                 r0_start,
    input  logic [3:0]                           r0_operation,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   r0_vec_a,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   r0_vec_b,
    input  logic [DATA_WIDTH-1:0]                r0_scalar,
    output logic                                 r0_busy,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   r0_result,
    output logic                                 r0_result_valid,

    input  logic                                 r1_start,
    input  logic [3:0]                           r1_operation,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   r1_vec_a,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   r1_vec_b,
    input  logic [DATA_WIDTH-1:0]                r1_scalar,
    output logic                                 r1_busy,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   r1_result,
    output logic                                 r1_result_valid,

    output logic                                 vp_start,
    output logic [3:0]                           vp_operation,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_vec_a,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_vec_b,
    output logic [DATA_WIDTH-1:0]                vp_scalar,
    input  logic                                 vp_busy,
    input  logic                                 vp_result_valid,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_result,

    output logic                                 grant_id,
    output logic                                 timeout_err
);

    localparam int unsigned VEC_W = VECTOR_WIDTH * DATA_WIDTH;
    localparam int unsigned OP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Per-port request views, indexed by port number
    logic [1:0]            start_c;
    logic [OP_W-1:0]       in_op_c    [2];
    logic [VEC_W-1:0]      in_a_c     [2];
    logic [VEC_W-1:0]      in_b_c     [2];
    logic [DATA_WIDTH-1:0] in_s_c     [2];

    // Holding registers and pending flags
    logic [1:0]            pend_q, pend_d;
    logic [OP_W-1:0]       hold_op_q  [2];
    logic [VEC_W-1:0]      hold_a_q   [2];
    logic [VEC_W-1:0]      hold_b_q   [2];
    logic [DATA_WIDTH-1:0] hold_s_q   [2];

    // Arbitration state
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  grant_sel_c;

    // Registered outputs
    logic                  vp_start_q, vp_start_d;
    logic [OP_W-1:0]       vp_op_q, vp_op_d;
    logic [VEC_W-1:0]      vp_a_q, vp_a_d;
    logic [VEC_W-1:0]      vp_b_q, vp_b_d;
    logic [DATA_WIDTH-1:0] vp_s_q, vp_s_d;
    logic [VEC_W-1:0]      res_q      [2];
    logic [VEC_W-1:0]      res_d      [2];
    logic [1:0]            res_valid_q, res_valid_d;

    logic                  timeout_hit_c;

    assign start_c    = {r1_start, r0_start};
    assign in_op_c[0] = r0_operation;
    assign in_op_c[1] = r1_operation;
    assign in_a_c[0]  = r0_vec_a;
    assign in_a_c[1]  = r1_vec_a;
    assign in_b_c[0]  = r0_vec_b;
    assign in_b_c[1]  = r1_vec_b;
    assign in_s_c[0]  = r0_scalar;
    assign in_s_c[1]  = r1_scalar;

    // Round-robin pick: on a tie take the port not granted last, else the one pending
    assign grant_sel_c = pend_q[1] & (~pend_q[0] | ~last_grant_q);

`ifdef VP_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_err_q;

    // Counts cycles spent in WAIT; restarts on every other state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // Expiry on the last permitted WAIT cycle; a real result wins a tie
    assign timeout_hit_c = (state_q == ST_WAIT) && !vp_result_valid &&
                           (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit_c) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit_c = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if ((|pend_q) && !vp_busy) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (vp_result_valid || timeout_hit_c) state_d = ST_RETURN;
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        pend_d       = pend_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        vp_start_d   = 1'b0;
        vp_op_d      = vp_op_q;
        vp_a_d       = vp_a_q;
        vp_b_d       = vp_b_q;
        vp_s_d       = vp_s_q;
        res_d[0]     = res_q[0];
        res_d[1]     = res_q[1];
        res_valid_d  = 2'b00;

        // A start is accepted only while that port is free
        for (int i = 0; i < 2; i++) begin
            if (start_c[i] && !pend_q[i]) pend_d[i] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_ISSUE) begin
                    grant_d      = grant_sel_c;
                    last_grant_d = grant_sel_c;
                end
            end
            ST_ISSUE: begin
                // Command registers hold this payload until the next ISSUE
                vp_start_d = 1'b1;
                vp_op_d    = hold_op_q[grant_q];
                vp_a_d     = hold_a_q[grant_q];
                vp_b_d     = hold_b_q[grant_q];
                vp_s_d     = hold_s_q[grant_q];
            end
            ST_WAIT: begin
                if (state_d == ST_RETURN) begin
                    res_valid_d[grant_q] = 1'b1;
                    res_d[grant_q]       = vp_result_valid ? vp_result : '0;
                end
            end
            ST_RETURN: begin
                pend_d[grant_q] = 1'b0;
            end
            default: ;
        endcase
    end

    // Holding registers capture the payload of an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                hold_op_q[i] <= '0;
                hold_a_q[i]  <= '0;
                hold_b_q[i]  <= '0;
                hold_s_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start_c[i] && !pend_q[i]) begin
                    hold_op_q[i] <= in_op_c[i];
                    hold_a_q[i]  <= in_a_c[i];
                    hold_b_q[i]  <= in_b_c[i];
                    hold_s_q[i]  <= in_s_c[i];
                end
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= 2'b00;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            vp_start_q   <= 1'b0;
            vp_op_q      <= '0;
            vp_a_q       <= '0;
            vp_b_q       <= '0;
            vp_s_q       <= '0;
            res_q[0]     <= '0;
            res_q[1]     <= '0;
            res_valid_q  <= 2'b00;
        end else begin
            pend_q       <= pend_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            vp_start_q   <= vp_start_d;
            vp_op_q      <= vp_op_d;
            vp_a_q       <= vp_a_d;
            vp_b_q       <= vp_b_d;
            vp_s_q       <= vp_s_d;
            res_q[0]     <= res_d[0];
            res_q[1]     <= res_d[1];
            res_valid_q  <= res_valid_d;
        end
    end

    assign r0_busy         = pend_q[0];
    assign r1_busy         = pend_q[1];
    assign r0_result       = res_q[0];
    assign r1_result       = res_q[1];
    assign r0_result_valid = res_valid_q[0];
    assign r1_result_valid = res_valid_q[1];
    assign vp_start        = vp_start_q;
    assign vp_operation    = vp_op_q;
    assign vp_vec_a        = vp_a_q;
    assign vp_vec_b        = vp_b_q;
    assign vp_scalar       = vp_s_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_vp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vp_arbiter
// Directed testbench for vp_arbiter with hand-computed expected values.
// The bench plays the role of the vector processor by driving vp_busy,
// vp_result_valid and vp_result directly.
// -----------------------------------------------------------------------------
module tb_vp_arbiter;

`ifdef VP_ARB_TIMEOUT_EN
    localparam int unsigned TO_CYC = 8;
`else
    localparam int unsigned TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_start, r1_start;
    logic [3:0]  r0_operation, r1_operation;
    logic [63:0] r0_vec_a, r0_vec_b, r1_vec_a, r1_vec_b;
    logic [15:0] r0_scalar, r1_scalar;
    logic        r0_busy, r1_busy;
    logic [63:0] r0_result, r1_result;
    logic        r0_result_valid, r1_result_valid;
    logic        vp_start;
    logic [3:0]  vp_operation;
    logic [63:0] vp_vec_a, vp_vec_b;
    logic [15:0] vp_scalar;
    logic        vp_busy, vp_result_valid;
    logic [63:0] vp_result;
    logic        grant_id, timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int vp_start_cnt = 0;
    int rv_cnt = 0;

    vp_arbiter #(
        .DATA_WIDTH     (16),
        .VECTOR_WIDTH   (4),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .r0_start        (r0_start),
        .r0_operation    (r0_operation),
        .r0_vec_a        (r0_vec_a),
        .r0_vec_b        (r0_vec_b),
        .r0_scalar       (r0_scalar),
        .r0_busy         (r0_busy),
        .r0_result       (r0_result),
        .r0_result_valid (r0_result_valid),
        .r1_start        (r1_start),
        .r1_operation    (r1_operation),
        .r1_vec_a        (r1_vec_a),
        .r1_vec_b        (r1_vec_b),
        .r1_scalar       (r1_scalar),
        .r1_busy         (r1_busy),
        .r1_result       (r1_result),
        .r1_result_valid (r1_result_valid),
        .vp_start        (vp_start),
        .vp_operation    (vp_operation),
        .vp_vec_a        (vp_vec_a),
        .vp_vec_b        (vp_vec_b),
        .vp_scalar       (vp_scalar),
        .vp_busy         (vp_busy),
        .vp_result_valid (vp_result_valid),
        .vp_result       (vp_result),
        .grant_id        (grant_id),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    // Count command and result strobes on the inactive edge
    always @(negedge clk) begin
        if (vp_start) vp_start_cnt <= vp_start_cnt + 1;
        if (r0_result_valid || r1_result_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until vp_start is seen, bounded
    task automatic wait_vp_start();
        int n;
        n = 0;
        while (!vp_start && n < 20) begin
            tick();
            n++;
        end
        if (!vp_start) chk("vp_start_wait_expired", 64'd0, 64'd1);
    endtask

    // One-cycle VP result; returns sampling in the RETURN cycle
    task automatic respond(input logic [63:0] res);
        vp_result_valid = 1'b1;
        vp_result       = res;
        tick();
        vp_result_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int base_vs;
        int base_rv;
        logic [3:0] exp_op;

        rst_n = 1'b0;
        r0_start = 1'b0; r1_start = 1'b0;
        r0_operation = '0; r1_operation = '0;
        r0_vec_a = '0; r0_vec_b = '0; r1_vec_a = '0; r1_vec_b = '0;
        r0_scalar = '0; r1_scalar = '0;
        vp_busy = 1'b0; vp_result_valid = 1'b0; vp_result = '0;
        tick();
        tick();

        // Reset state
        chk("rst_r0_busy",     64'(r0_busy), 64'd0);
        chk("rst_r1_busy",     64'(r1_busy), 64'd0);
        chk("rst_vp_start",    64'(vp_start), 64'd0);
        chk("rst_grant_id",    64'(grant_id), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_r0_result",   r0_result, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single request on an idle arbiter
        r0_start = 1'b1; r0_operation = 4'd4;
        r0_vec_a = 64'hFF00_0000_0000_FF00; r0_vec_b = 64'h0102_0304_0506_0708;
        r0_scalar = 16'h0080;
        base_vs = vp_start_cnt;
        tick();                                   // edge E
        r0_start = 1'b0;
        chk("t1_busy_after_start", 64'(r0_busy), 64'd1);
        chk("t1_no_vp_start_e",    64'(vp_start), 64'd0);
        tick();                                   // edge E+1
        chk("t1_no_vp_start_e1",   64'(vp_start), 64'd0);
        tick();                                   // edge E+2
        chk("t1_vp_start",     64'(vp_start), 64'd1);
        chk("t1_vp_operation", 64'(vp_operation), 64'd4);
        chk("t1_vp_vec_a",     vp_vec_a, 64'hFF00_0000_0000_FF00);
        chk("t1_vp_vec_b",     vp_vec_b, 64'h0102_0304_0506_0708);
        chk("t1_vp_scalar",    64'(vp_scalar), 64'h0080);
        chk("t1_grant_id",     64'(grant_id), 64'd0);
        tick();
        chk("t1_vp_start_one_cycle", 64'(vp_start), 64'd0);
        chk("t1_vp_operation_held",  64'(vp_operation), 64'd4);
        respond(64'h7F80_0000_0000_7F80);
        chk("t1_r0_result_valid", 64'(r0_result_valid), 64'd1);
        chk("t1_r1_result_valid", 64'(r1_result_valid), 64'd0);
        chk("t1_r0_result",       r0_result, 64'h7F80_0000_0000_7F80);
        tick();
        chk("t1_r0_valid_dropped", 64'(r0_result_valid), 64'd0);
        chk("t1_r0_busy_dropped",  64'(r0_busy), 64'd0);
        chk("t1_r0_result_held",   r0_result, 64'h7F80_0000_0000_7F80);
        chk("t1_vp_start_count",   64'(vp_start_cnt - base_vs), 64'd1);

        // Simultaneous requests after reset: port 0 first, then alternation
        do_reset();
        for (int p = 0; p < 3; p++) begin
            r0_start = 1'b1; r0_operation = 4'(1 + 2 * p);
            r1_start = 1'b1; r1_operation = 4'(2 + 2 * p);
            tick();
            r0_start = 1'b0; r1_start = 1'b0;
            for (int j = 0; j < 2; j++) begin
                exp_op = 4'(1 + 2 * p + j);
                wait_vp_start();
                chk($sformatf("t2_p%0d_grant%0d", p, j), 64'(grant_id), 64'(j));
                chk($sformatf("t2_p%0d_op%0d", p, j), 64'(vp_operation), 64'(exp_op));
                respond(64'(64'hA000 + 64'(exp_op)));
                if (j == 0) begin
                    chk($sformatf("t2_p%0d_r0_valid", p), 64'(r0_result_valid), 64'd1);
                    chk($sformatf("t2_p%0d_r0_result", p), r0_result, 64'(64'hA000 + 64'(exp_op)));
                end else begin
                    chk($sformatf("t2_p%0d_r1_valid", p), 64'(r1_result_valid), 64'd1);
                    chk($sformatf("t2_p%0d_r1_result", p), r1_result, 64'(64'hA000 + 64'(exp_op)));
                end
                tick();
            end
        end

        // Second start while busy is dropped; start from the other port in WAIT
        base_vs = vp_start_cnt;
        r0_start = 1'b1; r0_operation = 4'd3; r0_vec_a = 64'h1111;
        tick();
        r0_operation = 4'd9; r0_vec_a = 64'h9999;     // r0_busy is high now
        tick();
        r0_start = 1'b0;
        wait_vp_start();
        chk("t3_r0_op",    64'(vp_operation), 64'd3);
        chk("t3_r0_vec_a", vp_vec_a, 64'h1111);
        r1_start = 1'b1; r1_operation = 4'd7;         // in WAIT
        tick();
        r1_start = 1'b0;
        chk("t3_r1_busy", 64'(r1_busy), 64'd1);
        respond(64'h5555);
        chk("t3_r0_valid", 64'(r0_result_valid), 64'd1);
        tick();                                        // RETURN -> IDLE
        tick();                                        // IDLE -> ISSUE
        tick();
        chk("t3_r1_vp_start_immediate", 64'(vp_start), 64'd1);
        chk("t3_r1_op",    64'(vp_operation), 64'd7);
        chk("t3_r1_grant", 64'(grant_id), 64'd1);
        respond(64'h6666);
        chk("t3_r1_valid", 64'(r1_result_valid), 64'd1);
        tick();
        tick();
        tick();
        chk("t3_vp_start_count", 64'(vp_start_cnt - base_vs), 64'd2);
        chk("t3_r0_not_reissued", 64'(r0_busy), 64'd0);

        // vp_busy holds off the grant; stray result in IDLE is ignored
        vp_busy = 1'b1;
        base_vs = vp_start_cnt;
        base_rv = rv_cnt;
        r1_start = 1'b1; r1_operation = 4'd5;
        tick();
        r1_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) vp_result_valid = 1'b1;
            if (k == 5) vp_result_valid = 1'b0;
            tick();
        end
        chk("t4_no_vp_start_while_busy", 64'(vp_start_cnt - base_vs), 64'd0);
        chk("t4_no_stray_strobe",        64'(rv_cnt - base_rv), 64'd0);
        chk("t4_r1_still_pending",       64'(r1_busy), 64'd1);
        vp_busy = 1'b0;
        wait_vp_start();
        chk("t4_grant_after_busy", 64'(grant_id), 64'd1);
        chk("t4_op_after_busy",    64'(vp_operation), 64'd5);
        respond(64'h7777);
        chk("t4_r1_result", r1_result, 64'h7777);
        tick();

        // Reset in WAIT clears everything at once; later result ignored
        r0_start = 1'b1; r0_operation = 4'd6;
        tick();
        r0_start = 1'b0;
        wait_vp_start();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_r0_busy",   64'(r0_busy), 64'd0);
        chk("t5_rst_r0_result", r0_result, 64'd0);
        chk("t5_rst_r1_result", r1_result, 64'd0);
        chk("t5_rst_vp_op",     64'(vp_operation), 64'd0);
        chk("t5_rst_grant",     64'(grant_id), 64'd0);
        tick();
        rst_n = 1'b1;
        base_rv = rv_cnt;
        tick();
        vp_result_valid = 1'b1; vp_result = 64'hDEAD;
        tick();
        vp_result_valid = 1'b0;
        tick();
        tick();
        chk("t5_no_strobe_after_reset", 64'(rv_cnt - base_rv), 64'd0);
        chk("t5_r0_result_zero",        r0_result, 64'd0);

        // Watchdog behaviour in WAIT
        base_rv = rv_cnt;
        r1_start = 1'b1; r1_operation = 4'd2;
        tick();
        r1_start = 1'b0;
        wait_vp_start();                          // first WAIT cycle
`ifdef VP_ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) tick();
        chk("t6_no_strobe_before_limit", 64'(r1_result_valid), 64'd0);
        tick();
        chk("t6_timeout_strobe",  64'(r1_result_valid), 64'd1);
        chk("t6_timeout_result",  r1_result, 64'd0);
        chk("t6_timeout_err",     64'(timeout_err), 64'd1);
        tick();
        chk("t6_r1_busy_cleared", 64'(r1_busy), 64'd0);
        chk("t6_timeout_sticky",  64'(timeout_err), 64'd1);
`else
        for (int k = 0; k < 120; k++) tick();
        chk("t6_wait_persists",  64'(rv_cnt - base_rv), 64'd0);
        chk("t6_r1_still_busy",  64'(r1_busy), 64'd1);
        chk("t6_timeout_err_0",  64'(timeout_err), 64'd0);
        respond(64'hBEEF);
        chk("t6_late_result",    r1_result, 64'hBEEF);
        tick();
        chk("t6_r1_busy_cleared", 64'(r1_busy), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
